// File: rtl/smart_input_conditioner.sv
// smart_input_conditioner: synchronizes and debounces raw switches/buttons, turns buttons
// into manual toggles, and latches smoke/gas hazards until acknowledged.
module smart_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sw_mode,
    input  logic sw_motion,
    input  logic sw_smoke,
    input  logic sw_gas,
    input  logic sw_door,
    input  logic sw_temp_high,
    input  logic sw_temp_low,
    input  logic btn_light,
    input  logic btn_fan,
    input  logic btn_ac,
    input  logic btn_heat,
    input  logic btn_cool,
    input  logic btn_alarm_ack,
    output logic mode_select,
    output logic motion_sensor,
    output logic door_sensor,
    output logic temperature_sensor_high,
    output logic temperature_sensor_low,
    output logic temp_fault,
    output logic smoke_sensor,
    output logic gas_leak_sensor,
    output logic manual_light_control,
    output logic manual_fan_control,
    output logic manual_ac_control,
    output logic manual_heating_control,
    output logic manual_cooling_control
);
    localparam int N = 13;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] IDLE = 2'd0, ALARM = 2'd1, HELD = 2'd2;

    // bit map: 0 light, 1 fan, 2 ac, 3 heat, 4 cool, 5 ack, 6 mode, 7 motion,
    // 8 smoke, 9 gas, 10 door, 11 temp_high, 12 temp_low
    logic [N-1:0]  raw, s1_q, s2_q, st_q, st_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [6:0]    dly_q;
    logic [5:0]    rise;
    logic [4:0]    tp, tgl_q, tgl_d;
    logic          mode_fall, heat_p, cool_p;
    logic [1:0]    smoke_q, smoke_d, gas_q, gas_d;
    logic [2:0]    temp_q, temp_d;

    assign raw = {sw_temp_low, sw_temp_high, sw_door, sw_gas, sw_smoke, sw_motion, sw_mode,
                  btn_alarm_ack, btn_cool, btn_heat, btn_ac, btn_fan, btn_light};

    function automatic logic [1:0] haz_next(input logic [1:0] s, input logic lvl, input logic ack);
        return lvl ? ALARM : (s == ALARM) ? HELD : (s == HELD && !ack) ? HELD : IDLE;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            st_d[k]  = (s2_q[k] != st_q[k] && cnt_q[k] == LAST) ? s2_q[k] : st_q[k];
            cnt_d[k] = (s2_q[k] != st_q[k] && cnt_q[k] != LAST) ? cnt_q[k] + 1'b1 : '0;
        end
    end

    assign rise      = st_q[5:0] & ~dly_q[5:0];
    assign mode_fall = dly_q[6] & ~st_q[6];
    assign tp        = rise[4:0] & {5{st_q[6]}};
    assign heat_p    = tp[3] & ~tp[4];
    assign cool_p    = tp[4] & ~tp[3];

    // a pulse that turns one of heat/cool on forces the other off
    always_comb begin
        tgl_d[2:0] = mode_fall ? 3'b000 : tgl_q[2:0] ^ tp[2:0];
        tgl_d[3]   = mode_fall ? 1'b0 : heat_p ? ~tgl_q[3] : (cool_p & ~tgl_q[4]) ? 1'b0 : tgl_q[3];
        tgl_d[4]   = mode_fall ? 1'b0 : cool_p ? ~tgl_q[4] : (heat_p & ~tgl_q[3]) ? 1'b0 : tgl_q[4];
    end

    assign smoke_d = haz_next(smoke_q, st_q[8], rise[5]);
    assign gas_d   = haz_next(gas_q, st_q[9], rise[5]);
    assign temp_d  = {st_q[11] & st_q[12], st_q[11] & ~st_q[12], st_q[12] & ~st_q[11]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            st_q    <= '0;
            dly_q   <= '0;
            tgl_q   <= '0;
            smoke_q <= IDLE;
            gas_q   <= IDLE;
            temp_q  <= '0;
            for (int k = 0; k < N; k++) cnt_q[k] <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            st_q    <= st_d;
            dly_q   <= st_q[6:0];
            tgl_q   <= tgl_d;
            smoke_q <= smoke_d;
            gas_q   <= gas_d;
            temp_q  <= temp_d;
            for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign mode_select             = st_q[6];
    assign motion_sensor           = st_q[7];
    assign door_sensor             = st_q[10];
    assign temp_fault              = temp_q[2];
    assign temperature_sensor_high = temp_q[1];
    assign temperature_sensor_low  = temp_q[0];
    assign smoke_sensor            = smoke_q != IDLE;
    assign gas_leak_sensor         = gas_q != IDLE;
    assign manual_light_control    = tgl_q[0];
    assign manual_fan_control      = tgl_q[1];
    assign manual_ac_control       = tgl_q[2];
    assign manual_heating_control  = tgl_q[3];
    assign manual_cooling_control  = tgl_q[4];
endmodule

// File: tb/tb_smart_input_conditioner.sv
// tb_smart_input_conditioner: directed test-plan scenarios plus randomized stimulus,
// all checked every cycle against a sample-window reference model.
module tb_smart_input_conditioner;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] raw = '0;
    int          total = 0;
    int          bad = 0;

    logic mode_o, motion_o, door_o, th_o, tl_o, tf_o, smoke_o, gas_o;
    logic light_o, fan_o, ac_o, heat_o, cool_o;
    logic [12:0] dut_vec, exp_vec;

    always #5 clock = ~clock;

    smart_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset_n(reset_n),
        .sw_mode(raw[6]), .sw_motion(raw[7]), .sw_smoke(raw[8]), .sw_gas(raw[9]),
        .sw_door(raw[10]), .sw_temp_high(raw[11]), .sw_temp_low(raw[12]),
        .btn_light(raw[0]), .btn_fan(raw[1]), .btn_ac(raw[2]), .btn_heat(raw[3]),
        .btn_cool(raw[4]), .btn_alarm_ack(raw[5]),
        .mode_select(mode_o), .motion_sensor(motion_o), .door_sensor(door_o),
        .temperature_sensor_high(th_o), .temperature_sensor_low(tl_o), .temp_fault(tf_o),
        .smoke_sensor(smoke_o), .gas_leak_sensor(gas_o),
        .manual_light_control(light_o), .manual_fan_control(fan_o), .manual_ac_control(ac_o),
        .manual_heating_control(heat_o), .manual_cooling_control(cool_o)
    );

    assign dut_vec = {mode_o, motion_o, door_o, th_o, tl_o, tf_o, smoke_o, gas_o,
                      light_o, fan_o, ac_o, heat_o, cool_o};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw samples are kept in a history; a level changes once the
    // last D synchronized samples all disagree with it.
    logic [12:0] rh [0:D+1];
    logic [12:0] m_st = '0;
    logic [6:0]  m_dly = '0;
    logic [4:0]  m_tgl = '0;
    logic        m_th = 0, m_tl = 0, m_tf = 0;
    logic [1:0]  m_sm = '0, m_gs = '0;

    function automatic logic [1:0] haz(input logic [1:0] oh, input logic lvl, input logic ack);
        logic on;
        on = lvl | (oh[1] & ~(oh[0] & ack));
        return {on, on & ~lvl};
    endfunction

    initial for (int j = 0; j <= D + 1; j++) rh[j] = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j <= D + 1; j++) rh[j] = '0;
            m_st = '0; m_dly = '0; m_tgl = '0; m_th = 0; m_tl = 0; m_tf = 0;
            m_sm = '0; m_gs = '0;
        end else begin
            logic [5:0] p;
            logic same;
            p = m_st[5:0] & ~m_dly[5:0];
            if (m_dly[6] && !m_st[6]) m_tgl = '0;
            else if (m_st[6]) begin
                m_tgl[2:0] = m_tgl[2:0] ^ p[2:0];
                if (p[3] && !p[4]) begin
                    if (!m_tgl[3]) m_tgl[4:3] = 2'b01; else m_tgl[3] = 1'b0;
                end
                if (p[4] && !p[3]) begin
                    if (!m_tgl[4]) m_tgl[4:3] = 2'b10; else m_tgl[4] = 1'b0;
                end
            end
            m_tf = m_st[11] && m_st[12];
            m_th = m_st[11] && !m_st[12];
            m_tl = m_st[12] && !m_st[11];
            m_sm = haz(m_sm, m_st[8], p[5]);
            m_gs = haz(m_gs, m_st[9], p[5]);
            m_dly = m_st[6:0];
            for (int j = D + 1; j > 0; j--) rh[j] = rh[j-1];
            rh[0] = raw;
            for (int k = 0; k < 13; k++) begin
                same = 1'b1;
                for (int j = 3; j <= D + 1; j++) if (rh[j][k] != rh[2][k]) same = 1'b0;
                if (same && rh[2][k] != m_st[k]) m_st[k] = rh[2][k];
            end
        end
    end

    assign exp_vec = {m_st[6], m_st[7], m_st[10], m_th, m_tl, m_tf, m_sm[1], m_gs[1],
                      m_tgl[0], m_tgl[1], m_tgl[2], m_tgl[3], m_tgl[4]};

    always @(negedge clock) check("model", {3'b0, dut_vec}, {3'b0, exp_vec});

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int b);
        raw[b] = 1'b1;
        tick(8);
        raw[b] = 1'b0;
        tick(10);
    endtask

    initial begin
        tick(3);
        check("reset_outs", {3'b0, dut_vec}, 16'h0);
        reset_n = 1'b1;
        tick(2);
        raw[7] = 1'b1; tick(3); raw[7] = 1'b0; tick(10);
        check("motion_glitch", motion_o, 1'b0);
        raw[7] = 1'b1;
        tick(D + 1);
        check("motion_edge5", motion_o, 1'b0);
        tick(1);
        check("motion_edge6", motion_o, 1'b1);
        tick(4); raw[7] = 1'b0; tick(10);

        raw[6] = 1'b1; tick(10);
        check("mode_on", mode_o, 1'b1);
        press(3);
        check("heat_on", {heat_o, cool_o}, 2'b10);
        press(4);
        check("cool_on", {heat_o, cool_o}, 2'b01);
        raw[3] = 1'b1; raw[4] = 1'b1; tick(8); raw[3] = 1'b0; raw[4] = 1'b0; tick(10);
        check("heat_cool_same", {heat_o, cool_o}, 2'b01);
        press(0); press(1);
        check("light_fan_on", {light_o, fan_o}, 2'b11);
        raw[6] = 1'b0; tick(10);
        check("auto_clears", {light_o, fan_o, ac_o, heat_o, cool_o}, 5'b0);
        press(0);
        check("auto_ignored", light_o, 1'b0);

        raw[8] = 1'b1; tick(8);
        check("smoke_set", smoke_o, 1'b1);
        raw[8] = 1'b0; tick(10);
        check("smoke_held", smoke_o, 1'b1);
        press(5);
        check("smoke_acked", smoke_o, 1'b0);
        raw[8] = 1'b1; tick(10); press(5);
        check("smoke_ack_active", smoke_o, 1'b1);
        raw[8] = 1'b0; tick(10); press(5);

        raw[11] = 1'b1; raw[12] = 1'b1; tick(10);
        check("temp_conflict", {th_o, tl_o, tf_o}, 3'b001);
        raw[12] = 1'b0; tick(10);
        check("temp_high", {th_o, tl_o, tf_o}, 3'b100);
        raw[11] = 1'b0; tick(10);

        raw[6] = 1'b1; tick(10); press(2);
        raw[9] = 1'b1; raw[0] = 1'b1; tick(3);
        #1 reset_n = 1'b0;
        #1 check("async_reset", {3'b0, dut_vec}, 16'h0);
        tick(2);
        reset_n = 1'b1;
        raw[0] = 1'b0; raw[6] = 1'b0;
        tick(D + 2);
        check("gas_edge6", gas_o, 1'b0);
        tick(1);
        check("gas_edge7", gas_o, 1'b1);
        raw[9] = 1'b0; tick(10); press(5);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            for (int k = 0; k < 13; k++) if ($urandom_range(0, 9) == 0) raw[k] = ~raw[k];
            if ($urandom_range(0, 599) == 0) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
